// File: rtl/prog_sequencer.sv
// Run controller for the core's program counter: loads the base address of the
// current program slot, enables the core until halt or watchdog, then advances the slot.
module prog_sequencer #(
  parameter int             L          = 10,
  parameter int             NPROG      = 3,
  parameter logic [L-1:0]   BASE0      = '0,
  parameter logic [L-1:0]   BASE1      = '0,
  parameter logic [L-1:0]   BASE2      = '0,
  parameter logic [L-1:0]   BASE3      = '0,
  parameter int             CW         = 16,
  parameter int             MAX_CYCLES = 1000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  output logic          PCLoad,
  output logic [L-1:0]  PCLoadAddr,
  output logic          CoreEn,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [1:0]    LAST_IDX = 2'(NPROG - 1);
  // Count value seen during the MAX_CYCLES-th RUN cycle; the increment lands it on MAX_CYCLES.
  localparam logic [CW-1:0] WD_LAST  = CW'(MAX_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    prog_idx_q, prog_idx_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    // NOTE: every variable gets a hold default before the case, so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d       = S_LOAD;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + 1'b1;
        // Halt outranks the watchdog when both land on the same cycle.
        if (Halt) begin
          state_d = S_FINISH;
        end else if (cycle_count_q == WD_LAST) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end
      end
      S_FINISH: begin
        state_d    = S_IDLE;
        prog_idx_d = (prog_idx_q == LAST_IDX) ? 2'd0 : prog_idx_q + 2'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: Reset is synchronous here, so it sits inside the clocked branch and the sensitivity list holds only Clk.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      prog_idx_q    <= 2'd0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_idx_q    <= prog_idx_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    case (prog_idx_q)
      2'd0:    PCLoadAddr = BASE0;
      2'd1:    PCLoadAddr = BASE1;
      2'd2:    PCLoadAddr = BASE2;
      default: PCLoadAddr = BASE3;
    endcase
  end

  // Every output is a decode of registered state: no input reaches an output combinationally.
  assign PCLoad     = (state_q == S_LOAD);
  assign CoreEn     = (state_q == S_RUN);
  assign Done       = (state_q == S_FINISH);
  assign Busy       = (state_q != S_IDLE);
  assign Timeout    = timeout_q;
  assign ProgIdx    = prog_idx_q;
  assign CycleCount = cycle_count_q;

endmodule
